rank_filter_core: RTL and testbench

Parametrised, fully pipelined rank-order selector for the median-filter datapath. Takes a window of `ELEMENT_NUM` unsigned pixels per beat and returns the pixel of a runtime-selected rank (min, median, max or any rank), or the rounded mean of two adjacent ranks. It sits between the window-forming line buffer and the output pixel stream. It adds valid/ready flow control and per-beat rank selection on top of the fixed-median sorter.

---
 rtl/median_pkg.sv | 40 ++++
 rtl/cmp_swap.sv | 39 +++
 rtl/rank_filter_core.sv | 144 ++++++++++++++
 tb/tb_rank_filter_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and elaboration-time helpers for the rank-order filter datapath.
// Sizing functions and the bitonic partner map are evaluated only at elaboration.
package median_pkg;

  localparam int unsigned SB_RANK_W    = 6;   // wide enough for windows up to 64
  localparam logic [63:0] PAD_ALL_ONES = '1;  // pad value, sliced to DATA_WIDTH by users

  typedef struct packed {
    logic [SB_RANK_W-1:0] rank;
    logic                 avg;
  } sideband_t;

  function automatic int sort_levels(input int n);
    int l = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) l = i + 1;
    end
    return l;
  endfunction

  function automatic int sort_stages(input int n);
    int l = sort_levels(n);
    return l * (l + 1) / 2;
  endfunction

  // All-ascending bitonic form: each level opens with a mirrored compare across
  // the block, then halves the stride down to 1.
  function automatic int stage_partner(input int s, input int i);
    int st = 0;
    int p  = i;
    for (int m = 1; m <= 6; m++) begin
      for (int t = 0; t < m; t++) begin
        if (st == s) p = (t == 0) ? (i ^ ((1 << m) - 1)) : (i ^ (1 << (m - 1 - t)));
        st++;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// One registered compare-exchange pair: smaller value to the lower lane.
// Advances only when enabled so the whole sorter can stall as one.
module cmp_swap #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic [DATA_WIDTH-1:0] hi_o
);

  logic [DATA_WIDTH-1:0] lo_d, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, hi_q;

  always_comb begin
    // NOTE: defaults first so every path assigns lo_d/hi_d and no latch is inferred.
    lo_d = a_i;
    hi_d = b_i;
    if (a_i > b_i) begin
      lo_d = b_i;
      hi_d = a_i;
    end
  end

  // NOTE: data flops have no reset; the reset-cleared valid pipeline marks them meaningless.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: rtl/rank_filter_core.sv
// Pipelined rank-order selector: bitonic sort of one window per beat, then pick
// one rank or the rounded mean of two adjacent ranks, under valid/ready control.
module rank_filter_core
  import median_pkg::*;
#(
  parameter int ELEMENT_NUM = 25,
  parameter int DATA_WIDTH  = 8,
  parameter int RANK_W      = $clog2(ELEMENT_NUM)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*ELEMENT_NUM-1:0] in_pixels,
  input  logic [RANK_W-1:0]                 in_rank,
  input  logic                              in_avg,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_pixel,
  output logic                              out_clamped
);

  localparam int N    = ELEMENT_NUM;
  localparam int L    = sort_levels(N);
  localparam int S    = sort_stages(N);
  localparam int P2   = 1 << L;
  localparam int LAST = N - 1;
  localparam logic [DATA_WIDTH-1:0] PAD = PAD_ALL_ONES[DATA_WIDTH-1:0];

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // lane[s] is the column entering compare stage s; lane[S] is fully sorted.
  logic [DATA_WIDTH-1:0] lane [0:S][0:P2-1];
  logic [DATA_WIDTH-1:0] pix_d [0:N-1];
  logic [DATA_WIDTH-1:0] pix_q [0:N-1];

  always_comb begin
    for (int k = 0; k < N; k++) pix_d[k] = in_pixels[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (adv) pix_q <= pix_d;
  end

  for (genvar k = 0; k < P2; k++) begin : g_col0
    if (k < N) begin : g_data
      assign lane[0][k] = pix_q[k];
    end else begin : g_pad
      for (genvar s = 0; s <= S; s++) begin : g_pad_stage
        assign lane[s][k] = PAD;
      end
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int PARTNER = stage_partner(s, i);
      if (PARTNER > i && PARTNER < N) begin : g_cmp
        cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
          .clk  (clk),
          .en   (adv),
          .a_i  (lane[s][i]),
          .b_i  (lane[s][PARTNER]),
          .lo_o (lane[s+1][i]),
          .hi_o (lane[s+1][PARTNER])
        );
      end else if (PARTNER >= N) begin : g_pass
        // Partner is a pad, which is never smaller, so the data just moves on.
        logic [DATA_WIDTH-1:0] hold_d, hold_q;
        assign hold_d = lane[s][i];
        always_ff @(posedge clk) begin
          if (adv) hold_q <= hold_d;
        end
        assign lane[s+1][i] = hold_q;
      end
    end
  end

  logic [S:0] valid_d, valid_q;
  sideband_t  sb_d [0:S];
  sideband_t  sb_q [0:S];

  always_comb begin
    valid_d      = {valid_q[S-1:0], in_valid};
    sb_d[0].rank = SB_RANK_W'(in_rank);
    sb_d[0].avg  = in_avg;
    for (int s = 1; s <= S; s++) sb_d[s] = sb_q[s-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   valid_q <= '0;
    else if (adv) valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (adv) sb_q <= sb_d;
  end

  logic [RANK_W-1:0]     sel_lo, sel_hi;
  logic                  clamp_d;
  logic [DATA_WIDTH-1:0] out_pixel_d;

  always_comb begin
    sel_lo  = RANK_W'(LAST);
    clamp_d = 1'b1;
    if (sb_q[S].rank <= SB_RANK_W'(LAST)) begin
      sel_lo  = sb_q[S].rank[RANK_W-1:0];
      clamp_d = 1'b0;
    end
    sel_hi = sel_lo + RANK_W'(1);
    // No rank above the top one: average the top rank with itself.
    if (sb_q[S].avg && sel_lo == RANK_W'(LAST)) begin
      sel_hi  = sel_lo;
      clamp_d = 1'b1;
    end
    out_pixel_d = lane[S][sel_lo];
    if (sb_q[S].avg) begin
      out_pixel_d = DATA_WIDTH'(({1'b0, lane[S][sel_lo]} + {1'b0, lane[S][sel_hi]}
                                 + (DATA_WIDTH+1)'(1)) >> 1);
    end
  end

  logic                  out_valid_q, out_clamped_q;
  logic [DATA_WIDTH-1:0] out_pixel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_pixel_q   <= '0;
      out_clamped_q <= 1'b0;
    end else if (adv) begin
      out_valid_q   <= valid_q[S];
      out_pixel_q   <= out_pixel_d;
      out_clamped_q <= clamp_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pixel   = out_pixel_q;
  assign out_clamped = out_clamped_q;

endmodule

// File: tb/tb_rank_filter_core.sv
// Bench for rank_filter_core: an N=25 instance against a sort-based scoreboard,
// plus a small N=4 instance for the averaging corner cases.
module tb_rank_filter_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_avg = 1'b0, out_ready = 1'b1;
  logic [199:0] in_pixels = '0;
  logic [4:0]   in_rank = '0;
  logic         in_ready, out_valid, out_clamped;
  logic [7:0]   out_pixel;

  logic        in_valid_b = 1'b0, in_avg_b = 1'b0, out_ready_b = 1'b1;
  logic [31:0] in_pixels_b = '0;
  logic [1:0]  in_rank_b = '0;
  logic        in_ready_b, out_valid_b, out_clamped_b;
  logic [7:0]  out_pixel_b;

  rank_filter_core #(.ELEMENT_NUM(25), .DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixels(in_pixels), .in_rank(in_rank), .in_avg(in_avg),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_clamped(out_clamped)
  );

  rank_filter_core #(.ELEMENT_NUM(4), .DATA_WIDTH(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pixels(in_pixels_b), .in_rank(in_rank_b), .in_avg(in_avg_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pixel(out_pixel_b),
    .out_clamped(out_clamped_b)
  );

  typedef struct {
    int pix;
    bit clamped;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sort the window, then apply the rank / clamp / averaging rules.
  function automatic exp_t model(input logic [199:0] pix, input int n, input int rank, input bit avg);
    int   v[25];
    int   tmp, r;
    exp_t e;
    for (int k = 0; k < n; k++) v[k] = int'(pix[k*8 +: 8]);
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        tmp = v[j]; v[j] = v[j-1]; v[j-1] = tmp;
      end
    end
    r         = (rank > n - 1) ? n - 1 : rank;
    e.clamped = (rank > n - 1);
    e.pix     = v[r];
    if (avg) begin
      if (r == n - 1) e.clamped = 1'b1;
      else            e.pix = (v[r] + v[r+1] + 1) / 2;
    end
    return e;
  endfunction

  // One cycle on the main instance: drive at negedge, score 1 unit later.
  task automatic drive(input bit v, input logic [199:0] pix, input int rank, input bit avg, input bit ordy);
    in_valid  = v;
    in_pixels = pix;
    in_rank   = 5'(rank);
    in_avg    = avg;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_pixel", 32'(out_pixel), 32'(exp_q[0].pix));
        check("out_clamped", 32'(out_clamped), 32'(exp_q[0].clamped));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(model(pix, 25, rank, avg));
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, 0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) idle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    idle();
  endtask

  task automatic latency_run(input logic [199:0] pix, input int rank, input int exp_pix);
    int lat;
    drive(1'b1, pix, rank, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      idle();
      lat++;
    end
    check("latency", 32'(lat), 32'd17);
    check("latency_pixel", 32'(out_pixel), 32'(exp_pix));
    check("latency_clamped", 32'(out_clamped), 32'd0);
    idle();
    check("single_output", 32'(out_valid), 32'd0);
  endtask

  task automatic run_b(input logic [31:0] pix, input int rank, input bit avg, input int exp_pix, input bit exp_cl);
    int lat;
    in_valid_b  = 1'b1;
    in_pixels_b = pix;
    in_rank_b   = 2'(rank);
    in_avg_b    = avg;
    #1;
    check("b_in_ready", 32'(in_ready_b), 32'd1);
    @(negedge clk);
    in_valid_b = 1'b0;
    lat = 1;
    while (!out_valid_b && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b_latency", 32'(lat), 32'd5);
    check("b_pixel", 32'(out_pixel_b), 32'(exp_pix));
    check("b_clamped", 32'(out_clamped_b), 32'(exp_cl));
    @(negedge clk);
    check("b_single_output", 32'(out_valid_b), 32'd0);
  endtask

  logic [199:0] desc;
  logic [199:0] rp;
  int           rr, n_acc;
  bit           ra, have;

  initial begin
    for (int k = 0; k < 25; k++) desc[k*8 +: 8] = 8'(24 - k);

    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_pixel", 32'(out_pixel), 32'd0);
    check("reset_out_clamped", 32'(out_clamped), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    latency_run(desc, 12, 12);

    drive(1'b1, desc, 0, 1'b0, 1'b1);
    drive(1'b1, desc, 24, 1'b0, 1'b1);
    drive(1'b1, desc, 31, 1'b0, 1'b1);
    drain();

    run_b({8'd13, 8'd255, 8'd10, 8'd200}, 1, 1'b1, 107, 1'b0);
    run_b({8'd13, 8'd255, 8'd10, 8'd200}, 3, 1'b1, 255, 1'b1);
    run_b({8'd13, 8'd255, 8'd10, 8'd200}, 0, 1'b0, 10, 1'b0);

    for (int r = 0; r < 25; r++) drive(1'b1, {25{8'h80}}, r, 1'b0, 1'b1);
    drive(1'b1, {25{8'h80}}, 24, 1'b1, 1'b1);
    for (int r = 0; r < 25; r++) drive(1'b1, {25{8'hFF}}, r, 1'b0, 1'b1);
    drive(1'b1, {25{8'hFF}}, 24, 1'b1, 1'b1);
    drive(1'b1, {25{8'hFF}}, 31, 1'b1, 1'b1);
    drain();

    // Random traffic; a refused beat is held until the core takes it.
    n_acc = 0;
    have  = 1'b0;
    for (int c = 0; c < 6000 && n_acc < 200; c++) begin
      if (!have) begin
        have = ($urandom_range(0, 3) != 0);
        ra   = ($urandom_range(0, 1) == 1);
        rr   = int'($urandom_range(0, 31));
        for (int k = 0; k < 25; k++) begin
          if (c % 3 == 0) rp[k*8 +: 8] = 8'($urandom_range(0, 3) * 85);
          else            rp[k*8 +: 8] = 8'($urandom_range(0, 255));
        end
      end
      drive(have, rp, rr, ra, $urandom_range(0, 1) == 1);
      if (last_acc) begin
        have = 1'b0;
        n_acc++;
      end
    end
    check("random_accepted", 32'(n_acc), 32'd200);
    drain();

    for (int k = 0; k < 10; k++) drive(1'b1, desc, k, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_pixel", 32'(out_pixel), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      #1;
      check("in_reset_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("post_reset_out_valid", 32'(out_valid), 32'd0);
      idle();
    end
    latency_run(desc, 5, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
